regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Shares the single write port of the 16-entry register file between N requesters (ALU writeback, load unit, control unit, ...) using round-robin arbitration with a valid/ready handshake. It also runs a clear sequence that walks all 16 addresses and writes zero, blocking requesters meanwhile. It sits between the writeback sources and the register file's write_enable / inp_write_address0 / inp_write_data inputs. All outputs to the register file are registered.

## Interface
- W, 16: data width; matches the register file width.
- N, 3: number of write requesters (2..8).

- clk  input  1  rising-edge clock.
- reset_asynchronous_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester write request (valid).
- req_address  input  4*N  packed write addresses; requester i uses bits [4i+3:4i].
- req_data  input  W*N  packed write data; requester i uses bits [W*i+W-1:W*i].
- ready  output  N  combinational grant, one-hot or zero; transfer when req[i] & ready[i].
- clear_start  input  1  single-cycle pulse requesting a full clear.
- busy  output  1  high while in CLEAR.
- clear_done  output  1  one-cycle pulse after the last clear write is issued.
- rf_write_enable  output  1  to register file write_enable.
- rf_write_address  output  4  to register file write address.
- rf_write_data  output  W  to register file write data.

## Operation
- States: RUN, CLEAR. Reset state is RUN.
- Register state: 4-bit clear counter; round-robin pointer last_grant (0..N-1).
- Reset values: last_grant = N-1 (requester 0 has top priority first), counter = 0, rf_write_enable = 0, rf_write_address = 0, rf_write_data = 0, busy = 0, clear_done = 0.
- RUN, clear_start = 0: search from requester (last_grant+1) mod N upward, wrapping. The first i with req[i]=1 gets ready[i]=1. All other ready bits are 0. If no request, ready = 0.
- On transfer: at the next edge, rf_write_enable=1, rf_write_address=req_address[i], rf_write_data=req_data[i], last_grant=i.
- On no transfer: rf_write_enable=0; address and data hold their previous values.
- RUN, clear_start = 1: ready = 0 that cycle, even if requests are pending; clear takes precedence. Next state is CLEAR with counter = 0.
- CLEAR: ready = 0 and busy = 1. Each cycle, register rf_write_enable=1, rf_write_address=counter, rf_write_data=0, then increment counter.
- When the counter wraps from 15, the next state is RUN. clear_done is registered high for exactly the one cycle in which the address-15 write is presented.
- last_grant is unchanged across a clear.
- clear_start during CLEAR is ignored; it neither restarts nor extends the sequence.
- A requester must hold req, address and data stable until it sees ready. It may drop req before being granted (no penalty). Changing address or data while req=1 and ready=0 is illegal.
- Duplicate addresses from different requesters are not merged; they are written in grant order.
- Reset assertion mid-CLEAR aborts immediately. Outputs take reset values and the state is RUN; the register file keeps any partially cleared contents.

## Timing
- ready is combinational from req, state and last_grant. There is no combinational path from req_address or req_data.
- Write latency: a transfer in cycle C makes rf_write_enable high in cycle C+1. The register file captures the data at the end of C+1.
- Throughput: one write per cycle, back-to-back, including from the same requester.
- Fairness: with all N requesters continuously requesting, each is granted exactly once in every N consecutive cycles.
- Clear: clear_start in cycle C gives writes to addresses 0..15 in cycles C+1..C+16, with busy high over the same cycles.
  - clear_done is high in C+16.
  - ready may first reassert in C+17; the earliest arbitrated write appears in C+18.
- Clear timing is not affected by request activity.

## Test plan
- Reset then idle: all outputs 0 and ready=0. Then req=3'b001, addr 5, data 16'hABCD gives ready=001 at once; next cycle rf_write_enable=1, address 5, data 16'hABCD.
- All three requesters request continuously with distinct addresses 1/2/3: grant order is 0,1,2,0,1,2. rf_write_address follows 1,2,3,1,2,3 one cycle later with no idle cycles.
- last_grant=0, then req=3'b101: requester 2 is granted before 0. Repeat the check for every rotation.
- clear_start with req=3'b111 in the same cycle: ready stays 0 for 17 cycles (C..C+16); addresses 0..15 are written with data 0; busy=1 for 16 cycles; a single clear_done pulse. Arbitration then resumes with the pointer unchanged.
- Second clear_start pulse at the 8th clear cycle: the sequence still ends after address 15 with exactly one clear_done.
- reset_asynchronous_n pulsed low mid-clear (between edges): rf_write_enable, busy and clear_done drop to 0 immediately, without waiting for a clock edge. After release the block is in RUN with requester 0 at top priority.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Round-robin write-port scheduler for a 16-entry register file.
// Shares one write port between N requesters with a valid/ready handshake.
// Also runs a clear sequence that writes zero to all 16 addresses while
// requesters are held off. Every output to the register file is registered.
module regfile_write_scheduler #(
  parameter int W = 16,
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             reset_asynchronous_n,
  input  logic [N-1:0]     req,
  input  logic [4*N-1:0]   req_address,
  input  logic [W*N-1:0]   req_data,
  output logic [N-1:0]     ready,
  input  logic             clear_start,
  output logic             busy,
  output logic             clear_done,
  output logic             rf_write_enable,
  output logic [3:0]       rf_write_address,
  output logic [W-1:0]     rf_write_data
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {RUN, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   last_grant_q, last_grant_d;
  logic            we_q, we_d;
  logic [3:0]      addr_q, addr_d;
  logic [W-1:0]    data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned (no latch).
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = PW'((int'(last_grant_q) + off) % N);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant is only visible in RUN and is suppressed by a same-cycle clear request.
  always_comb begin
    ready = '0;
    if (state_q == RUN && !clear_start && grant_any) begin
      ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic: arbitrated writes in RUN, zero-fill walk in CLEAR.
  // The address-0 clear write is issued on the clear_start edge so that the
  // walk occupies exactly the 16 cycles after the request; the final CLEAR
  // cycle (counter 15) issues nothing and returns to RUN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      RUN: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          addr_d  = 4'd0;
          data_d  = '0;
        end else if (grant_any) begin
          we_d         = 1'b1;
          addr_d       = req_address[4*grant_idx +: 4];
          data_d       = req_data[W*grant_idx +: W];
          last_grant_d = grant_idx;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          state_d = RUN;
        end else begin
          busy_d = 1'b1;
          we_d   = 1'b1;
          addr_d = cnt_q + 4'd1;
          data_d = '0;
          done_d = (cnt_q == 4'hE);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and registered outputs; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      state_q      <= RUN;
      cnt_q        <= 4'd0;
      last_grant_q <= PW'(N - 1);
      we_q         <= 1'b0;
      addr_q       <= 4'd0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy             = busy_q;
  assign clear_done       = done_q;
  assign rf_write_enable  = we_q;
  assign rf_write_address = addr_q;
  assign rf_write_data    = data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed self-checking bench for regfile_write_scheduler (W=16, N=3).
module tb_regfile_write_scheduler;

  localparam int W = 16;
  localparam int N = 3;

  logic             clk;
  logic             reset_asynchronous_n;
  logic [N-1:0]     req;
  logic [4*N-1:0]   req_address;
  logic [W*N-1:0]   req_data;
  logic [N-1:0]     ready;
  logic             clear_start;
  logic             busy;
  logic             clear_done;
  logic             rf_write_enable;
  logic [3:0]       rf_write_address;
  logic [W-1:0]     rf_write_data;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_scheduler #(.W(W), .N(N)) dut (
    .clk                  (clk),
    .reset_asynchronous_n (reset_asynchronous_n),
    .req                  (req),
    .req_address          (req_address),
    .req_data             (req_data),
    .ready                (ready),
    .clear_start          (clear_start),
    .busy                 (busy),
    .clear_done           (clear_done),
    .rf_write_enable      (rf_write_enable),
    .rf_write_address     (rf_write_address),
    .rf_write_data        (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 32'(rf_write_enable), 32'(we));
    chk({tag, "_addr"}, 32'(rf_write_address), 32'(a));
    chk({tag, "_data"}, 32'(rf_write_data), 32'(d));
  endtask

  initial begin
    int g;
    reset_asynchronous_n = 1'b0;
    req         = '0;
    clear_start = 1'b0;
    req_address = {4'd3, 4'd2, 4'd5};
    req_data    = {16'h3333, 16'h2222, 16'hABCD};

    // Reset and idle
    tick(); tick();
    reset_asynchronous_n = 1'b1;
    tick();
    chk_write("idle", 1'b0, 4'd0, 16'h0000);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(clear_done), 32'd0);
    chk("idle_ready", 32'(ready), 32'd0);

    // Single request from requester 0
    req = 3'b001;
    #1 chk("single_ready", 32'(ready), 32'b001);
    tick();
    chk_write("single", 1'b1, 4'd5, 16'hABCD);
    req = 3'b000;
    #1 chk("drop_ready", 32'(ready), 32'd0);
    tick();
    chk_write("hold", 1'b0, 4'd5, 16'hABCD);

    // All requesting: after grant to 0, order is 1,2,0,1,2,0, back-to-back
    req_address = {4'd3, 4'd2, 4'd1};
    req_data    = {16'h3333, 16'h2222, 16'h1111};
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      g = (1 + k) % 3;
      #1 chk("rr_ready", 32'(ready), 32'(1 << g));
      tick();
      chk_write("rr", 1'b1, 4'(g + 1), 16'(16'h1111 * (g + 1)));
    end

    // Rotation checks with non-adjacent requests (last grant is 0)
    req = 3'b101;
    #1 chk("rot_lg0_101", 32'(ready), 32'b100);
    tick();
    chk_write("rot_a", 1'b1, 4'd3, 16'h3333);
    #1 chk("rot_lg2_101", 32'(ready), 32'b001);
    tick();
    chk_write("rot_b", 1'b1, 4'd1, 16'h1111);
    req = 3'b010;
    #1 chk("rot_lg0_010", 32'(ready), 32'b010);
    tick();
    req = 3'b101;
    #1 chk("rot_lg1_101", 32'(ready), 32'b100);
    tick();
    req = 3'b110;
    #1 chk("rot_lg2_110", 32'(ready), 32'b010);
    tick();
    req = 3'b011;
    #1 chk("rot_lg1_011", 32'(ready), 32'b001);
    tick();
    chk_write("rot_c", 1'b1, 4'd1, 16'h1111);

    // Clear with all requests pending (last grant is 0)
    req = 3'b111;
    clear_start = 1'b1;
    #1 chk("clr_c_ready", 32'(ready), 32'd0);
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk_write("clr", 1'b1, 4'(k), 16'h0000);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_done", 32'(clear_done), 32'(k == 15));
      chk("clr_ready", 32'(ready), 32'd0);
      tick();
    end
    #1;
    chk("clr_end_busy", 32'(busy), 32'd0);
    chk("clr_end_done", 32'(clear_done), 32'd0);
    chk("clr_end_we", 32'(rf_write_enable), 32'd0);
    chk("clr_resume_ready", 32'(ready), 32'b010);
    tick();
    chk_write("clr_resume", 1'b1, 4'd2, 16'h2222);
    req = 3'b000;
    tick();

    // Clear with a second clear_start pulse at the 8th clear cycle
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      clear_start = (k == 7);
      #1;
      chk_write("clr2", 1'b1, 4'(k), 16'h0000);
      chk("clr2_busy", 32'(busy), 32'd1);
      chk("clr2_done", 32'(clear_done), 32'(k == 15));
      tick();
    end
    clear_start = 1'b0;
    #1;
    chk("clr2_end_busy", 32'(busy), 32'd0);
    chk("clr2_end_done", 32'(clear_done), 32'd0);
    chk("clr2_end_we", 32'(rf_write_enable), 32'd0);
    tick();
    chk("clr2_idle_we", 32'(rf_write_enable), 32'd0);

    // Reset pulse mid-clear, between clock edges
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("mid_pre_busy", 32'(busy), 32'd1);
    reset_asynchronous_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(rf_write_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(clear_done), 32'd0);
    chk("mid_rst_addr", 32'(rf_write_address), 32'd0);
    reset_asynchronous_n = 1'b1;
    req = 3'b111;
    #1 chk("post_rst_ready", 32'(ready), 32'b001);
    tick();
    chk_write("post_rst", 1'b1, 4'd1, 16'h1111);
    chk("post_rst_busy", 32'(busy), 32'd0);
    req = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
